// File: rtl/icache_fill_responder.sv
// Memory-side line-fill responder: one Avalon-MM burst read per icache miss, words streamed back with MEM_DONE.
// Optional fill statistics counters are enabled with `define ICACHE_FILL_STATS_EN.
module icache_fill_responder #(
  parameter int LINESIZE = 8,
  parameter int ADDRBITS = 30
) (
  input  logic                         CLK,
  input  logic                         rst_n,
  input  logic                         MEM_REQ,
  input  logic [31:0]                  MEM_ADDR,
  output logic                         MEM_DONE,
  output logic [31:0]                  MEM_DATA,
  input  logic                         abort,
  output logic                         busy,
  output logic [ADDRBITS-1:0]          avm_address,
  output logic [$clog2(LINESIZE):0]    avm_burstcount,
  output logic                         avm_read,
  input  logic                         avm_waitrequest,
  input  logic [31:0]                  avm_readdata,
  input  logic                         avm_readdatavalid
`ifdef ICACHE_FILL_STATS_EN
  ,
  output logic [31:0]                  stat_fills,
  output logic [31:0]                  stat_wait_cycles
`endif
);

  localparam int OFFB = $clog2(LINESIZE);
  localparam int CNTW = OFFB + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DATA} state_t;

  state_t            state_reg;
  logic [CNTW-1:0]   beat_cnt_reg;
  logic              discard_reg;
  logic [29:0]       line_word;
  logic              beat_last;
  logic              drop_beat;
  logic              unused_addr_bits;

  // Line-aligned word address; byte offset and in-line word offset are dropped.
  assign line_word        = {MEM_ADDR[31:OFFB+2], {OFFB{1'b0}}};
  assign unused_addr_bits = ^MEM_ADDR[OFFB+1:0];
  assign beat_last        = (beat_cnt_reg == CNTW'(LINESIZE - 1));
  assign drop_beat        = discard_reg | abort;
  assign avm_burstcount   = CNTW'(LINESIZE);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      MEM_DONE     <= 1'b0;
      MEM_DATA     <= 32'h0;
      avm_read     <= 1'b0;
      avm_address  <= '0;
      busy         <= 1'b0;
      beat_cnt_reg <= '0;
      discard_reg  <= 1'b0;
    end else begin
      MEM_DONE <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (MEM_REQ) begin
            avm_address  <= line_word[ADDRBITS-1:0];
            avm_read     <= 1'b1;
            busy         <= 1'b1;
            beat_cnt_reg <= '0;
            discard_reg  <= 1'b0;
            state_reg    <= ISSUE;
          end
        end
        ISSUE: begin
          // The read command must stay up until accepted, even when aborting.
          if (abort) discard_reg <= 1'b1;
          if (!avm_waitrequest) begin
            avm_read  <= 1'b0;
            state_reg <= DATA;
          end
        end
        DATA: begin
          if (abort) discard_reg <= 1'b1;
          if (avm_readdatavalid) begin
            beat_cnt_reg <= beat_cnt_reg + 1'b1;
            if (!drop_beat) begin
              MEM_DONE <= 1'b1;
              MEM_DATA <= avm_readdata;
            end
            if (beat_last) begin
              busy      <= 1'b0;
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef ICACHE_FILL_STATS_EN
  logic wait_cycle;

  // Cycles spent busy before the first data beat of the burst arrives.
  assign wait_cycle = busy && ((state_reg == ISSUE) ||
                      ((state_reg == DATA) && (beat_cnt_reg == '0) && !avm_readdatavalid));

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      stat_fills       <= 32'h0;
      stat_wait_cycles <= 32'h0;
    end else begin
      if ((state_reg == IDLE) && MEM_REQ && (stat_fills != 32'hFFFF_FFFF))
        stat_fills <= stat_fills + 32'h1;
      if (wait_cycle && (stat_wait_cycles != 32'hFFFF_FFFF))
        stat_wait_cycles <= stat_wait_cycles + 32'h1;
    end
  end
`endif

endmodule
